// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between NUM_REQ requesters, the arbiter and the single uart_transmitter.
// The slave modport is the arbiter's view; the master modport is the sources/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_data;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter feeding one uart_transmitter, with a stall watchdog.
// Optional UART_ARB_ID_HEADER_EN prefixes each packet with an 8'hA<id> source byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic               uart_sampling_clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   arb_bus,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout_pulse
);

`ifdef UART_ARB_ID_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;
`else
    typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

    state_t           state, state_nxt;
    logic [ID_W-1:0]  last_grant, last_grant_nxt, grant_nxt, pick;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic             timeout_nxt, any_req;
    logic             g_valid, g_last;
    logic [7:0]       g_data;

    // First requester at or after last_grant+1, wrapping; constant indices only.
    always_comb begin : rr_pick
        any_req = 1'b0;
        pick    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (!any_req && ((32'(last_grant) + off) % NUM_REQ) == r
                    && arb_bus.req_valid[r]) begin
                    any_req = 1'b1;
                    pick    = ID_W'(r);
                end
            end
        end
    end

    always_comb begin : grant_mux
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid = arb_bus.req_valid[i];
                g_last  = arb_bus.req_last[i];
                g_data  = arb_bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin : ready_steer
        arb_bus.req_ready = '0;
        if (state == STREAM) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_W'(i)) arb_bus.req_ready[i] = arb_bus.tx_ready;
            end
        end
    end

    always_comb begin : fsm_next
        state_nxt        = state;
        grant_nxt        = grant_id;
        last_grant_nxt   = last_grant;
        wd_cnt_nxt       = wd_cnt;
        timeout_nxt      = 1'b0;
        busy             = 1'b0;
        arb_bus.tx_valid = 1'b0;
        arb_bus.tx_data  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt  = pick;
                    wd_cnt_nxt = '0;
`ifdef UART_ARB_ID_HEADER_EN
                    state_nxt  = HDR;
`else
                    state_nxt  = STREAM;
`endif
                end
            end
`ifdef UART_ARB_ID_HEADER_EN
            HDR: begin
                busy             = 1'b1;
                arb_bus.tx_valid = 1'b1;
                arb_bus.tx_data  = {4'hA, 4'(grant_id)};
                wd_cnt_nxt       = '0;
                if (arb_bus.tx_ready) state_nxt = STREAM;
            end
`endif
            STREAM: begin
                busy             = 1'b1;
                arb_bus.tx_valid = g_valid;
                arb_bus.tx_data  = g_data;
                if (g_valid && arb_bus.tx_ready) begin
                    wd_cnt_nxt = '0;
                    if (g_last) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                    end
                end else if (!g_valid) begin
                    // Leaving when the count would reach TIMEOUT-1 registers the pulse into the IDLE cycle.
                    if (wd_cnt >= CNT_W'(TIMEOUT - 2)) begin
                        state_nxt      = IDLE;
                        timeout_nxt    = 1'b1;
                        last_grant_nxt = grant_id;
                        wd_cnt_nxt     = '0;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge uart_sampling_clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_id      <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant_id      <= grant_nxt;
            last_grant    <= last_grant_nxt;
            wd_cnt        <= wd_cnt_nxt;
            timeout_pulse <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, TIMEOUT=16); requesters are byte tables
// replayed on handshake, transmitter output is logged and compared to hand-written values.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       reset;
    logic       rst_cmd;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_pulse;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2),
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .uart_sampling_clk (clk),
        .reset             (reset),
        .arb_bus           (bus),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_pulse     (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pdata [4][8];
    logic       plast [4][8];
    int         len [4];
    int         pos [4];
    int         cyc = 0;

    logic [7:0] log_data [$];
    int         log_gid  [$];
    int         log_cyc  [$];
    logic [3:0] log_rdy  [$];
    logic       log_busy [$];
    int         pulse_n;
    int         pulse_cyc;
    logic       pulse_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after the falling edge, observe combinational outputs 1 time unit later.
    task automatic cycle(input logic rdy);
        @(negedge clk);
        reset = rst_cmd;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]       = (pos[i] < len[i]);
            bus.req_data[8*i +: 8] = (pos[i] < len[i]) ? pdata[i][pos[i]] : 8'h00;
            bus.req_last[i]        = (pos[i] < len[i]) ? plast[i][pos[i]] : 1'b0;
        end
        bus.tx_ready = rdy;
        #1;
        cyc++;
        if (bus.tx_valid && bus.tx_ready) begin
            log_data.push_back(bus.tx_data);
            log_gid.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
            log_rdy.push_back(bus.req_ready);
            log_busy.push_back(busy);
        end
        if (timeout_pulse) begin
            pulse_n++;
            pulse_cyc  = cyc;
            pulse_busy = busy;
        end
        for (int i = 0; i < 4; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) pos[i]++;
    endtask

    task automatic clear_logs();
        log_data.delete(); log_gid.delete(); log_cyc.delete();
        log_rdy.delete();  log_busy.delete();
        pulse_n = 0; pulse_cyc = 0; pulse_busy = 1'b0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        pdata[r][len[r]] = d;
        plast[r][len[r]] = l;
        len[r]++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin len[i] = 0; pos[i] = 0; end
        rst_cmd = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        rst_cmd = 1'b0;
        clear_logs();
    endtask

    // toggle=1 alternates tx_ready each cycle; the log length is always compared at the end.
    task automatic run_until(input string tag, input int n, input int budget, input logic toggle);
        logic rdy;
        int   k;
        rdy = 1'b0;
        k   = 0;
        while (log_data.size() < n && k < budget) begin
            rdy = toggle ? ~rdy : 1'b1;
            cycle(rdy);
            k++;
        end
        check(tag, 32'(log_data.size()), 32'(n));
    endtask

    initial begin
        int t0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
        reset = 1'b1; rst_cmd = 1'b1;
        do_reset();

        check("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_timeout", 32'(timeout_pulse), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));

`ifndef UART_ARB_ID_HEADER_EN
        // Req1 3-byte packet under toggling tx_ready.
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
        run_until("t1_count", 3, 40, 1'b1);
        check("t1_b0", 32'(log_data[0]), 32'h41);
        check("t1_b1", 32'(log_data[1]), 32'h42);
        check("t1_b2", 32'(log_data[2]), 32'h43);
        for (int i = 0; i < 3; i++) begin
            check("t1_gid", 32'(log_gid[i]), 32'(1));
            check("t1_rdy", 32'(log_rdy[i]), 32'h2);
        end
        check("t1_busy_at_last", 32'(log_busy[2]), 32'(1));
        cycle(1'b1);
        check("t1_busy_after", 32'(busy), 32'(0));
        check("t1_gid_after", 32'(grant_id), 32'(1));
        repeat (4) cycle(1'b1);
        check("t1_no_repeat", 32'(log_data.size()), 32'(3));

        // Req0 and req2 together: whole req0 packet, one IDLE cycle, then req2.
        do_reset();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        run_until("t2_count", 4, 30, 1'b0);
        check("t2_b0", {24'(log_gid[0]), log_data[0]}, 32'h0_10);
        check("t2_b1", {24'(log_gid[1]), log_data[1]}, 32'h0_11);
        check("t2_b2", {24'(log_gid[2]), log_data[2]}, 32'h2_20);
        check("t2_b3", {24'(log_gid[3]), log_data[3]}, 32'h2_21);
        check("t2_gap", 32'(log_cyc[2] - log_cyc[1]), 32'(2));

        // All four requesters streaming 1-byte packets: strict rotation.
        do_reset();
        for (int r = 0; r < 4; r++) repeat (3) push(r, 8'h30 + 8'(r), 1'b1);
        run_until("t3_count", 6, 40, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("t3_gid", 32'(log_gid[i]), 32'(i % 4));
            check("t3_data", 32'(log_data[i]), 32'h30 + 32'(i % 4));
        end
        for (int r = 0; r < 4; r++) len[r] = pos[r];

        // Req3 stalls after one byte; watchdog revokes, req1 then gets the grant.
        do_reset();
        push(3, 8'h77, 1'b0);
        run_until("t4_first", 1, 10, 1'b0);
        t0 = log_cyc[0];
        push(1, 8'h61, 1'b1);
        run_until("t4_second", 2, 30, 1'b0);
        repeat (3) cycle(1'b1);
        check("t4_pulse_count", 32'(pulse_n), 32'(1));
        check("t4_pulse_delay", 32'(pulse_cyc - t0), 32'(16));
        check("t4_pulse_busy", 32'(pulse_busy), 32'(0));
        check("t4_next", {24'(log_gid[1]), log_data[1]}, 32'h1_61);
        check("t4_next_delay", 32'(log_cyc[1] - t0), 32'(17));
        check("t4_total", 32'(log_data.size()), 32'(2));

        // Reset in the middle of a req1 packet, then the packet restarts.
        do_reset();
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
        run_until("t5_first", 1, 10, 1'b0);
        rst_cmd = 1'b1;
        cycle(1'b0);
        rst_cmd = 1'b0;
        pos[1] = 0;
        clear_logs();
        cycle(1'b1);
        check("t5_tx_valid", 32'(bus.tx_valid), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_grant_id", 32'(grant_id), 32'(0));
        check("t5_req_ready", 32'(bus.req_ready), 32'(0));
        run_until("t5_count", 3, 20, 1'b0);
        check("t5_b0", {24'(log_gid[0]), log_data[0]}, 32'h1_51);
        check("t5_b1", {24'(log_gid[1]), log_data[1]}, 32'h1_52);
        check("t5_b2", {24'(log_gid[2]), log_data[2]}, 32'h1_53);
`else
        // Header option: source-ID byte precedes the payload, requester not acknowledged for it.
        push(2, 8'h55, 1'b1);
        run_until("t6_count", 2, 20, 1'b0);
        check("t6_hdr", 32'(log_data[0]), 32'hA2);
        check("t6_hdr_rdy", 32'(log_rdy[0]), 32'h0);
        check("t6_hdr_busy", 32'(log_busy[0]), 32'(1));
        check("t6_data", 32'(log_data[1]), 32'h55);
        check("t6_data_rdy", 32'(log_rdy[1]), 32'h4);
        check("t6_gid", 32'(log_gid[1]), 32'(2));
        cycle(1'b1);
        check("t6_busy_after", 32'(busy), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1);
    end

endmodule
